// File: rtl/egress_offset_shifter.sv
// Egress offset stage: buffers whole packets, strips the metadata-specified body offset,
// re-aligns the remaining body bytes and rewrites the length/tail-invalid fields.
module egress_offset_shifter #(
  parameter int DATA_BYTES  = 16,
  parameter int FIFO_DEPTH  = 256,
  parameter int AFULL_LEVEL = 128,
  parameter int LEN_LSB     = 113,
  parameter int LEN_W       = 11,
  parameter int OFF_LSB     = 32,
  parameter int OFF_W       = 7,
  localparam int IW    = $clog2(DATA_BYTES),
  localparam int PKT_W = 8*DATA_BYTES + 2 + IW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_tdma_pkt_wr,
  input  logic [PKT_W-1:0] in_tdma_pkt,
  input  logic             in_tdma_valid_wr,
  input  logic             in_tdma_valid,
  output logic             out_tdma_pkt_almostfull,
  output logic             out_outputctrl_pkt_wr,
  output logic [PKT_W-1:0] out_outputctrl_pkt,
  output logic             out_outputctrl_valid_wr,
  output logic             out_outputctrl_valid,
  input  logic             in_outputctrl_pkt_almostfull,
  output logic [15:0]      out_drop_count
);
  localparam int DW     = 8*DATA_BYTES;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int VDEPTH = FIFO_DEPTH/4;
  localparam int VW     = $clog2(VDEPTH);
  localparam int DCW    = OFF_W - IW;
  localparam logic [AW:0]   B_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   B_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   B_AFULL = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW-1:0] BP_ONE  = AW'(1);
  localparam logic [VW:0]   V_ONE   = (VW+1)'(1);
  localparam logic [VW:0]   V_FULL  = (VW+1)'(VDEPTH);
  localparam logic [VW-1:0] VP_ONE  = VW'(1);
  localparam logic [IW:0]   N_V     = (IW+1)'(DATA_BYTES);
  localparam logic [DCW-1:0] DC_ONE = DCW'(1);

  typedef enum logic [2:0] {IDLE, DROP, META0, META1, DISCARD, PASS, SHIFT, TAIL} state_t;
  state_t state, state_n;

  // Beat FIFO (show-ahead)
  logic [PKT_W-1:0] bmem [FIFO_DEPTH];
  logic [AW-1:0]    b_wp, b_rp;
  logic [AW:0]      b_cnt;
  logic             b_push, b_pop, b_empty;
  logic [PKT_W-1:0] b_head;

  assign b_empty = (b_cnt == '0);
  assign b_push  = in_tdma_pkt_wr && (b_cnt != B_FULL);
  assign b_head  = bmem[b_rp];
  assign out_tdma_pkt_almostfull = (b_cnt >= B_AFULL);

  always_ff @(posedge clk) begin
    if (b_push) bmem[b_wp] <= in_tdma_pkt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_wp  <= '0;
      b_rp  <= '0;
      b_cnt <= '0;
    end else begin
      if (b_push) b_wp <= b_wp + BP_ONE;
      if (b_pop)  b_rp <= b_rp + BP_ONE;
      case ({b_push, b_pop})
        2'b10:   b_cnt <= b_cnt + B_ONE;
        2'b01:   b_cnt <= b_cnt - B_ONE;
        default: ;
      endcase
    end
  end

  // Per-packet valid flag FIFO (show-ahead)
  logic [VDEPTH-1:0] vmem;
  logic [VW-1:0]     v_wp, v_rp;
  logic [VW:0]       v_cnt;
  logic              v_push, v_pop, v_empty, v_head;

  assign v_empty = (v_cnt == '0);
  assign v_push  = in_tdma_valid_wr && (v_cnt != V_FULL);
  assign v_head  = vmem[v_rp];

  always_ff @(posedge clk) begin
    if (v_push) vmem[v_wp] <= in_tdma_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_wp  <= '0;
      v_rp  <= '0;
      v_cnt <= '0;
    end else begin
      if (v_push) v_wp <= v_wp + VP_ONE;
      if (v_pop)  v_rp <= v_rp + VP_ONE;
      case ({v_push, v_pop})
        2'b10:   v_cnt <= v_cnt + V_ONE;
        2'b01:   v_cnt <= v_cnt - V_ONE;
        default: ;
      endcase
    end
  end

  // Packet context and datapath
  logic [LEN_W-1:0] len_q, len_n;
  logic [OFF_W-1:0] off_q, off_n;
  logic [DCW-1:0]   dcnt_q, dcnt_n;
  logic [DW-1:0]    sr_q, sr_n;
  logic [IW:0]      vlast_q, vlast_n;
  logic [15:0]      drop_q, drop_n;
  logic             o_wr_n, o_vwr_n;
  logic [PKT_W-1:0] o_pkt_n;

  logic [IW-1:0]    s_q;
  logic [IW:0]      s_ext, v_cur;
  logic [LEN_W-1:0] len_in, off_in_ext, off_q_ext;
  logic [OFF_W-1:0] off_in;
  logic             head_tail, go;
  logic [2*DW-1:0]  cat;
  logic [DW-1:0]    shifted, tail_data;

  assign s_q        = off_q[IW-1:0];
  assign s_ext      = {1'b0, s_q};
  assign len_in     = b_head[LEN_LSB +: LEN_W];
  assign off_in     = b_head[OFF_LSB +: OFF_W];
  assign off_in_ext = {{(LEN_W-OFF_W){1'b0}}, off_in};
  assign off_q_ext  = {{(LEN_W-OFF_W){1'b0}}, off_q};
  assign head_tail  = (b_head[PKT_W-1 -: 2] == 2'b10);
  // An invalid count of 0 yields V=N through the IW+1-bit subtraction.
  assign v_cur      = N_V - {1'b0, b_head[PKT_W-3 -: IW]};
  assign go         = !in_outputctrl_pkt_almostfull;
  assign cat        = {sr_q, b_head[DW-1:0]} << {s_q, 3'b000};
  assign shifted    = cat[2*DW-1 -: DW];
  assign tail_data  = sr_q << {s_q, 3'b000};

  always_comb begin
    logic [PKT_W-1:0] md;
    logic [IW:0]      inv_t;
    state_n = state;
    len_n   = len_q;
    off_n   = off_q;
    dcnt_n  = dcnt_q;
    sr_n    = sr_q;
    vlast_n = vlast_q;
    drop_n  = drop_q;
    b_pop   = 1'b0;
    v_pop   = 1'b0;
    o_wr_n  = 1'b0;
    o_vwr_n = 1'b0;
    o_pkt_n = '0;
    md      = b_head;
    inv_t   = '0;
    case (state)
      IDLE: if (!v_empty && !b_empty) begin
        v_pop   = 1'b1;
        len_n   = len_in;
        off_n   = off_in;
        dcnt_n  = off_in[OFF_W-1:IW];
        state_n = (!v_head || off_in_ext >= len_in) ? DROP : META0;
      end
      DROP: if (go && !b_empty) begin
        b_pop = 1'b1;
        if (head_tail) begin
          if (drop_q != 16'hFFFF) drop_n = drop_q + 16'd1;
          state_n = IDLE;
        end
      end
      META0: if (go && !b_empty) begin
        b_pop = 1'b1;
        md[LEN_LSB +: LEN_W] = len_q - off_q_ext;
        o_wr_n  = 1'b1;
        o_pkt_n = md;
        state_n = META1;
      end
      META1: if (go && !b_empty) begin
        b_pop   = 1'b1;
        o_wr_n  = 1'b1;
        o_pkt_n = b_head;
        state_n = DISCARD;
      end
      DISCARD: if (go && !b_empty) begin
        if (dcnt_q != '0) begin
          b_pop  = 1'b1;
          dcnt_n = dcnt_q - DC_ONE;
        end else if (s_q == '0) begin
          state_n = PASS;
        end else begin
          b_pop = 1'b1;
          sr_n  = b_head[DW-1:0];
          if (head_tail) begin
            vlast_n = v_cur;
            state_n = TAIL;
          end else begin
            state_n = SHIFT;
          end
        end
      end
      PASS: if (go && !b_empty) begin
        b_pop   = 1'b1;
        o_wr_n  = 1'b1;
        o_pkt_n = b_head;
        if (head_tail) begin
          o_vwr_n = 1'b1;
          state_n = IDLE;
        end
      end
      SHIFT: if (go && !b_empty) begin
        b_pop   = 1'b1;
        sr_n    = b_head[DW-1:0];
        o_wr_n  = 1'b1;
        o_pkt_n = {2'b11, {IW{1'b0}}, shifted};
        if (head_tail) begin
          if (v_cur <= s_ext) begin
            inv_t   = s_ext - v_cur;
            o_pkt_n = {2'b10, inv_t[IW-1:0], shifted};
            o_vwr_n = 1'b1;
            state_n = IDLE;
          end else begin
            vlast_n = v_cur;
            state_n = TAIL;
          end
        end
      end
      TAIL: if (go) begin
        inv_t   = N_V - vlast_q + s_ext;
        o_wr_n  = 1'b1;
        o_pkt_n = {2'b10, inv_t[IW-1:0], tail_data};
        o_vwr_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      off_q   <= '0;
      dcnt_q  <= '0;
      sr_q    <= '0;
      vlast_q <= '0;
      drop_q  <= '0;
      out_outputctrl_pkt_wr   <= 1'b0;
      out_outputctrl_pkt      <= '0;
      out_outputctrl_valid_wr <= 1'b0;
    end else begin
      len_q   <= len_n;
      off_q   <= off_n;
      dcnt_q  <= dcnt_n;
      sr_q    <= sr_n;
      vlast_q <= vlast_n;
      drop_q  <= drop_n;
      out_outputctrl_pkt_wr   <= o_wr_n;
      out_outputctrl_pkt      <= o_pkt_n;
      out_outputctrl_valid_wr <= o_vwr_n;
    end
  end

  assign out_outputctrl_valid = out_outputctrl_valid_wr;
  assign out_drop_count       = drop_q;
endmodule

// File: tb/tb_egress_offset_shifter.sv
// Directed bench for egress_offset_shifter: packet build, expected-beat model, stall/drop/reset cases.
module tb_egress_offset_shifter;
  localparam int N  = 16;
  localparam int PW = 134;
  localparam int CW = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_wr = 1'b0;
  logic [PW-1:0] in_pkt = '0;
  logic          in_vwr = 1'b0;
  logic          in_v = 1'b0;
  logic          out_af;
  logic          o_wr;
  logic [PW-1:0] o_pkt;
  logic          o_vwr, o_v;
  logic [15:0]   drops;
  logic          tog_state = 1'b0;
  logic          tog_en = 1'b0;
  int            tog_cnt = 0;

  egress_offset_shifter #(.DATA_BYTES(16), .FIFO_DEPTH(256), .AFULL_LEVEL(128)) dut (
    .clk(clk),
    .reset(rst),
    .in_tdma_pkt_wr(in_wr),
    .in_tdma_pkt(in_pkt),
    .in_tdma_valid_wr(in_vwr),
    .in_tdma_valid(in_v),
    .out_tdma_pkt_almostfull(out_af),
    .out_outputctrl_pkt_wr(o_wr),
    .out_outputctrl_pkt(o_pkt),
    .out_outputctrl_valid_wr(o_vwr),
    .out_outputctrl_valid(o_v),
    .in_outputctrl_pkt_almostfull(tog_state),
    .out_drop_count(drops)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [PW+1:0] got_q[$];
  logic [PW+1:0] exp_q[$];
  logic [7:0]    body [256];
  int            wr_while_high = 0;
  logic          af_q = 1'b0;

  // Downstream backpressure toggles every 3 cycles while enabled
  always @(posedge clk) begin
    #1;
    if (!tog_en) begin
      tog_cnt   = 0;
      tog_state = 1'b0;
    end else begin
      tog_cnt++;
      if (tog_cnt == 3) begin
        tog_cnt   = 0;
        tog_state = ~tog_state;
      end
    end
  end

  always @(posedge clk) af_q <= tog_state;

  always @(negedge clk) begin
    if (!rst && (o_wr || o_vwr)) begin
      got_q.push_back({o_vwr, o_v, o_pkt});
      if (af_q) wr_while_high++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic put_beat(input logic [PW-1:0] b);
    in_pkt = b;
    in_wr  = 1'b1;
    @(posedge clk);
    #1;
    in_wr  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int off, input bit flag, input int seed);
    logic [PW-1:0] md0, md1, bt;
    int nb, ol;
    md0 = '0;
    md0[PW-1 -: 2] = 2'b01;
    md0[127:64] = {4{16'hC0DE ^ 16'(seed)}};
    md0[63:40]  = 24'h5A5A5A ^ 24'(seed);
    md0[113 +: 11] = 11'(len);
    md0[32 +: 7]   = 7'(off);
    md1 = {2'b11, 4'h0, {4{32'h1357_9BDF + 32'(seed)}}};
    for (int i = 0; i < len; i++) body[i] = 8'(i*3 + seed*11 + 1);
    put_beat(md0);
    put_beat(md1);
    nb = (len + N - 1) / N;
    for (int b = 0; b < nb; b++) begin
      bt = '0;
      bt[PW-1 -: 2] = (b == nb-1) ? 2'b10 : 2'b11;
      bt[131:128]   = (b == nb-1) ? 4'(nb*N - len) : 4'h0;
      for (int k = 0; k < N; k++)
        if (b*N + k < len) bt[127-8*k -: 8] = body[b*N + k];
      put_beat(bt);
    end
    in_v   = flag;
    in_vwr = 1'b1;
    @(posedge clk);
    #1;
    in_vwr = 1'b0;
    if (flag && off < len) begin
      md0[113 +: 11] = 11'(len - off);
      exp_q.push_back({2'b00, md0});
      exp_q.push_back({2'b00, md1});
      ol = len - off;
      nb = (ol + N - 1) / N;
      for (int b = 0; b < nb; b++) begin
        bt = '0;
        bt[PW-1 -: 2] = (b == nb-1) ? 2'b10 : 2'b11;
        bt[131:128]   = (b == nb-1) ? 4'(nb*N - ol) : 4'h0;
        for (int k = 0; k < N; k++)
          if (b*N + k < ol) bt[127-8*k -: 8] = body[off + b*N + k];
        exp_q.push_back({(b == nb-1) ? 2'b11 : 2'b00, bt});
      end
    end
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_count"}, CW'(got_q.size()), CW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), CW'(got_q[i]), CW'(exp_q[i]));
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  logic [PW+1:0] t;

  initial begin
    // Reset state
    @(negedge clk);
    check("reset_outputs", CW'({o_wr, o_vwr, o_v, out_af, drops, o_pkt}), '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Case 1: off=0 pass-through
    send_pkt(64, 0, 1'b1, 1);
    drain("c1");
    t = got_q[0];
    check("c1_len_field", CW'(t[113 +: 11]), CW'(64));
    check("c1_beats", CW'(got_q.size()), CW'(6));
    clear_q();

    // Case 2: off=5
    send_pkt(40, 5, 1'b1, 2);
    drain("c2");
    t = got_q[0];
    check("c2_len_field", CW'(t[113 +: 11]), CW'(35));
    t = got_q[2];
    check("c2_byte0", CW'(t[127:120]), CW'(8'h26));
    t = got_q[4];
    check("c2_tail_type", CW'(t[133:132]), CW'(2'b10));
    check("c2_tail_inv", CW'(t[131:128]), CW'(13));
    check("c2_beats", CW'(got_q.size()), CW'(5));
    clear_q();

    // Case 3: off=21 (one discarded beat, shift 5)
    send_pkt(40, 21, 1'b1, 3);
    drain("c3");
    t = got_q[0];
    check("c3_len_field", CW'(t[113 +: 11]), CW'(19));
    t = got_q[2];
    check("c3_byte0", CW'(t[127:120]), CW'(8'h61));
    t = got_q[3];
    check("c3_tail_inv", CW'(t[131:128]), CW'(13));
    check("c3_beats", CW'(got_q.size()), CW'(4));
    clear_q();

    // Case 4: drops
    send_pkt(20, 20, 1'b1, 4);
    repeat (40) @(posedge clk);
    #1;
    check("c4_off_eq_len_no_out", CW'(got_q.size()), CW'(0));
    check("c4_drop1", CW'(drops), CW'(1));
    send_pkt(40, 5, 1'b0, 5);
    repeat (40) @(posedge clk);
    #1;
    check("c4_flag0_no_out", CW'(got_q.size()), CW'(0));
    check("c4_drop2", CW'(drops), CW'(2));
    clear_q();

    // Case 5: case 2 under toggling backpressure
    wr_while_high = 0;
    tog_en = 1'b1;
    send_pkt(40, 5, 1'b1, 2);
    drain("c5");
    tog_en = 1'b0;
    check("c5_wr_while_af", CW'(wr_while_high), CW'(0));
    check("c5_beats", CW'(got_q.size()), CW'(5));
    clear_q();

    // Almostfull threshold at 128 queued beats
    for (int i = 0; i < 127; i++) put_beat({2'b11, 4'h0, 128'(i)});
    check("af_at_127", CW'(out_af), CW'(0));
    put_beat({2'b11, 4'h0, 128'h7F});
    check("af_at_128", CW'(out_af), CW'(1));
    rst = 1'b1;
    @(negedge clk);
    check("af_flushed", CW'(out_af), CW'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Case 6: reset mid-SHIFT, then clean packet
    send_pkt(40, 5, 1'b1, 6);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("c6_reset_outputs", CW'({o_wr, o_vwr, o_v, out_af, drops, o_pkt}), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    send_pkt(64, 0, 1'b1, 7);
    drain("c6");
    check("c6_beats", CW'(got_q.size()), CW'(6));
    check("c6_drops", CW'(drops), CW'(0));
    clear_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
